register_file: RTL
==================

// Module: register_file
// PURPOSE
//  Architectural register file with rename tags, directly downstream of the reorder buffer.
//  Holds 32 x 32-bit values plus per-register busy bit and producing RoB id.
//  Reorder buffer drives issue (mark rd busy, record tag) and commit (write value, release tag).
//  Decoder reads two source operands combinationally: value, or the RoB id it must wait on.
// PARAMETERS
//  ROB_ADDR   4    width of RoB id (= `RoB_addr from const.v); RoB depth 2**ROB_ADDR
//  NUM_REGS   32   architectural registers; x0 hardwired to zero
// PORTS
//  clk_in         in   1         single clock, all state on rising edge
//  rst_in         in   1         asynchronous reset, active-high
//  rdy_in         in   1         global enable; low = hold all state
//  clear          in   1         branch/jalr flush from RoB, registered there
//  issue_valid    in   1         RoB allocating an instruction that writes rd
//  issue_rd       in   5         destination register of issued instruction
//  issue_robid    in   ROB_ADDR  RoB entry (tail) allocated to it
//  commit_valid   in   1         RoB committing an instruction that writes rd
//  commit_rd      in   5         destination register of committed instruction
//  commit_robid   in   ROB_ADDR  RoB entry (head) being committed
//  commit_value   in   32        result to write
//  rs1 / rs2      in   5         decoder source register indices
//  rs1_busy       out  1         rs1 awaits an in-flight producer
//  rs1_dep        out  ROB_ADDR  producer RoB id when rs1_busy, else 0
//  rs1_value      out  32        register value when !rs1_busy, else 0
//  rs2_busy/rs2_dep/rs2_value    same for rs2
// BEHAVIOUR
//  Reset (async, rst_in=1): all value=0, busy=0, dep=0; outputs follow (busy=0, dep=0, value=0).
//  rdy_in=0 (not reset): no state change; read outputs stay combinational on current state.
//  Commit (rdy_in & commit_valid & commit_rd!=0): value[rd]<=commit_value at edge.
//   Release busy[rd] only if busy[rd] & dep[rd]==commit_robid & no same-cycle issue to that rd.
//  Issue (rdy_in & issue_valid & issue_rd!=0 & !clear): busy[rd]<=1, dep[rd]<=issue_robid.
//   Same-cycle issue and commit to same rd: issue wins for busy/dep, commit still writes value.
//  Clear (rdy_in & clear): busy[*]<=0, dep[*]<=0 for every register; issue ignored that cycle.
//   Commit in same cycle as clear still writes value (it is architecturally retired).
//  x0: never written, never busy; reads of x0 always return busy=0, dep=0, value=0.
//  Read path (combinational, zero latency), per port, priority order:
//   1 rs==0 -> not busy, value 0.
//   2 busy[rs] & commit_valid & commit_rd==rs & dep[rs]==commit_robid -> not busy,
//     value=commit_value (commit bypass).
//   3 busy[rs] -> busy=1, dep=dep[rs], value=0.
//   4 else -> busy=0, value=value[rs].
//  Same-cycle issue does not affect reads: decoder renames its own rd after reading sources.
//  Tag wrap-around: tags are RoB slots; stale commit (dep mismatch) writes value, keeps busy.
// STRUCTURE
//  `RoB_addr and register-count constants stay in shared const.v; no new typedefs.
//  Flat module: three arrays (value, busy, dep), one always block with async reset,
//  two identical read-port assigns; no sub-module warranted.
// TESTING
//  Reset mid-run: set busy[5], assert rst_in between edges -> rs1=5 reads busy=0, value=0 at once.
//  Issue x5 tag 3, then commit x5 tag 3 value 0xDEADBEEF -> after edge busy=0, value=0xDEADBEEF;
//   during commit cycle rs1=5 reads busy=0, value=0xDEADBEEF via bypass.
//  Issue x7 tag 2, issue x7 tag 6, commit x7 tag 2 value 0x11 -> value=0x11, busy=1, dep=6.
//  Same cycle: commit x9 tag 1 value 0x22 and issue x9 tag 4 -> busy=1, dep=4, value=0x22.
//  Issue x1,x2,x3 tags 1..3; clear with commit x1 tag 1 value 0x5 -> all busy=0, x1=0x5, x2,x3 old.
//  Issue/commit to x0 with value 0xFFFF; rdy_in=0 with issue x4 -> x0 reads 0, x4 unchanged.

Source files
------------

// File: rtl/register_file_pkg.sv
// ============================================================================
// Module : register_file_pkg
// Brief  : Shared sizing constants for the architectural register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package register_file_pkg;
    localparam int DEF_ROB_ADDR = 4;
    localparam int DEF_NUM_REGS = 32;
    localparam int REG_IDX_W    = 5;
    localparam int XLEN         = 32;
endpackage

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module : register_file
// Brief  : 32x32 architectural registers with busy bit and producing RoB tag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module register_file
    import register_file_pkg::*;
#(
    parameter int ROB_ADDR = DEF_ROB_ADDR,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [ROB_ADDR-1:0]  issue_robid,
    input  logic                 commit_valid,
    input  logic [REG_IDX_W-1:0] commit_rd,
    input  logic [ROB_ADDR-1:0]  commit_robid,
    input  logic [XLEN-1:0]      commit_value,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic                 rs1_busy,
    output logic [ROB_ADDR-1:0]  rs1_dep,
    output logic [XLEN-1:0]      rs1_value,
    output logic                 rs2_busy,
    output logic [ROB_ADDR-1:0]  rs2_dep,
    output logic [XLEN-1:0]      rs2_value
);

    logic [XLEN-1:0]     r_value [NUM_REGS];
    logic                r_busy  [NUM_REGS];
    logic [ROB_ADDR-1:0] r_dep   [NUM_REGS];

    logic w_commit_en;
    logic w_issue_en;
    logic w_release;

    assign w_commit_en = rdy_in && commit_valid && (commit_rd != '0);
    assign w_issue_en  = rdy_in && issue_valid && (issue_rd != '0) && !clear;
    // A newer issue to the same rd keeps the register renamed.
    assign w_release   = w_commit_en && r_busy[commit_rd]
                         && (r_dep[commit_rd] == commit_robid)
                         && !(w_issue_en && (issue_rd == commit_rd));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_value[i] <= '0;
                r_busy[i]  <= 1'b0;
                r_dep[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (w_commit_en) begin
                r_value[commit_rd] <= commit_value;
            end
            if (clear) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    r_busy[i] <= 1'b0;
                    r_dep[i]  <= '0;
                end
            end else begin
                if (w_release) begin
                    r_busy[commit_rd] <= 1'b0;
                end
                if (w_issue_en) begin
                    r_busy[issue_rd] <= 1'b1;
                    r_dep[issue_rd]  <= issue_robid;
                end
            end
        end
    end

    // Returns {busy, dep, value}; a matching commit this cycle bypasses the wait.
    function automatic logic [ROB_ADDR+XLEN:0] read_port(input logic [REG_IDX_W-1:0] rs);
        logic [ROB_ADDR+XLEN:0] res;
        res = '0;
        if (rs == '0) begin
            res = '0;
        end else if (r_busy[rs] && commit_valid && (commit_rd == rs)
                     && (r_dep[rs] == commit_robid)) begin
            res = {1'b0, {ROB_ADDR{1'b0}}, commit_value};
        end else if (r_busy[rs]) begin
            res = {1'b1, r_dep[rs], {XLEN{1'b0}}};
        end else begin
            res = {1'b0, {ROB_ADDR{1'b0}}, r_value[rs]};
        end
        return res;
    endfunction

    assign {rs1_busy, rs1_dep, rs1_value} = read_port(rs1);
    assign {rs2_busy, rs2_dep, rs2_value} = read_port(rs2);

endmodule

`default_nettype wire
